// File: rtl/crg_result_reader.sv
// Reads result words from the CRG result RAM and streams them MSB byte first to the UART TX path.
// Define CRG_READER_CKSUM_EN to append an XOR checksum byte after each word.
module crg_result_reader #(
  parameter int DATA_W = 768,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  word_cnt_i,
  output logic              ram_req_o,
  input  logic              ram_gnt_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // REQ   | read request held until granted
  // WAIT  | RAM data arrives, loaded into the shift register
  // SHIFT | presenting data bytes to the UART
  // CKSUM | presenting the per-word XOR byte (optional)
  // DONE  | one-cycle completion pulse
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd5;
`ifdef CRG_READER_CKSUM_EN
  localparam logic [2:0] ST_CKSUM = 3'd4;
`endif

  localparam int NBYTES = DATA_W / 8;
  localparam int BC_W   = $clog2(NBYTES + 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              ram_req_q, tx_valid_q, busy_q, done_q;
  logic              tx_valid_d;
  logic              hs;
  logic              word_end;
`ifdef CRG_READER_CKSUM_EN
  logic [7:0]        acc_q, acc_d;
`endif

  assign hs = tx_valid_q && tx_ready_i;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    words_d   = words_q;
    bcnt_d    = bcnt_q;
    shreg_d   = shreg_q;
    tx_data_d = tx_data_q;
    word_end  = 1'b0;
`ifdef CRG_READER_CKSUM_EN
    acc_d     = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          words_d = word_cnt_i;
          state_d = (word_cnt_i == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (ram_gnt_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        shreg_d   = ram_rdata_i;
        tx_data_d = ram_rdata_i[DATA_W-1 -: 8];
        bcnt_d    = BC_W'(NBYTES - 1);
`ifdef CRG_READER_CKSUM_EN
        acc_d     = 8'h00;
`endif
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (hs) begin
          shreg_d   = shreg_q << 8;
          tx_data_d = shreg_d[DATA_W-1 -: 8];
          bcnt_d    = bcnt_q - BC_W'(1);
`ifdef CRG_READER_CKSUM_EN
          acc_d     = acc_q ^ tx_data_q;
          if (bcnt_q == '0) begin
            tx_data_d = acc_q ^ tx_data_q;
            state_d   = ST_CKSUM;
          end
`else
          if (bcnt_q == '0) word_end = 1'b1;
`endif
        end
      end
`ifdef CRG_READER_CKSUM_EN
      ST_CKSUM: begin
        if (hs) word_end = 1'b1;
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Word finished: fetch the next address or wrap up the transfer.
    if (word_end) begin
      if (words_q == CNT_W'(1)) begin
        state_d = ST_DONE;
      end else begin
        words_d = words_q - CNT_W'(1);
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_REQ;
      end
    end
  end

  always_comb begin
    tx_valid_d = (state_d == ST_SHIFT);
`ifdef CRG_READER_CKSUM_EN
    if (state_d == ST_CKSUM) tx_valid_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      words_q    <= '0;
      bcnt_q     <= '0;
      shreg_q    <= '0;
      tx_data_q  <= 8'h00;
      ram_req_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CRG_READER_CKSUM_EN
      acc_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      bcnt_q     <= bcnt_d;
      shreg_q    <= shreg_d;
      tx_data_q  <= tx_data_d;
      ram_req_q  <= (state_d == ST_REQ);
      tx_valid_q <= tx_valid_d;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
`ifdef CRG_READER_CKSUM_EN
      acc_q      <= acc_d;
`endif
    end
  end

  assign ram_req_o  = ram_req_q;
  assign ram_addr_o = addr_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_crg_result_reader.sv
// Directed bench for crg_result_reader: RAM model, byte collector and per-test checks.
module tb_crg_result_reader;
  localparam int DATA_W = 768;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 9;
  localparam int NB     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] base_addr_i = '0;
  logic [CNT_W-1:0]  word_cnt_i = '0;
  logic              ram_req_o;
  logic              ram_gnt_i = 1'b0;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_rdata_i = '0;
  logic [7:0]        tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i = 1'b0;
  logic              busy_o;
  logic              done_o;

  crg_result_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .word_cnt_i(word_cnt_i), .ram_req_o(ram_req_o), .ram_gnt_i(ram_gnt_i),
    .ram_addr_o(ram_addr_o), .ram_rdata_i(ram_rdata_i), .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) if (ram_req_o && ram_gnt_i) ram_rdata_i <= mem[ram_addr_o];

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] addrs[$];
  int done_cnt, done_c, first_valid, grant_c, req_stall, req_moved, stab_err;
  int valid_cnt, req_cnt, last_hs_c, busy_c1, timed_out;

  task automatic build_exp(input logic [7:0] base, input int cnt);
    logic [7:0] a;
    logic [7:0] x;
    exp_q.delete();
    for (int w = 0; w < cnt; w++) begin
      a = base + 8'(w);
      x = 8'h00;
      for (int i = 0; i < NB; i++) begin
        exp_q.push_back(mem[a][DATA_W-1-8*i -: 8]);
        x = x ^ mem[a][DATA_W-1-8*i -: 8];
      end
`ifdef CRG_READER_CKSUM_EN
      exp_q.push_back(x);
`endif
    end
  endtask

  task automatic cmp_stream(input string tag, input int exp_len);
    int bad;
    bad = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) bad++;
    check({tag, "_len"}, got.size(), exp_len);
    check({tag, "_bytes_bad"}, bad, 0);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_req"}, ram_req_o, 0);
    check({tag, "_addr"}, ram_addr_o, 0);
    check({tag, "_valid"}, tx_valid_o, 0);
    check({tag, "_data"}, tx_data_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
  endtask

  task automatic run_xfer(input logic [7:0] base, input logic [8:0] cnt, input int rdy_mode,
                          input int gnt_delay, input int stop_bytes, input int mid_start);
    logic pv_hold, p_req, p_gnt;
    logic [7:0] pv_data, p_addr;
    pv_hold = 1'b0; p_req = 1'b0; p_gnt = 1'b1; pv_data = 8'h00; p_addr = 8'h00;
    got.delete(); addrs.delete();
    done_cnt = 0; done_c = -1; first_valid = -1; grant_c = -1; req_stall = 0; req_moved = 0;
    stab_err = 0; valid_cnt = 0; req_cnt = 0; last_hs_c = -1; busy_c1 = 0; timed_out = 1;
    @(negedge clk);
    base_addr_i = base; word_cnt_i = cnt; start_i = 1'b1;
    ram_gnt_i = (gnt_delay == 0); tx_ready_i = (rdy_mode == 0);
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      start_i = (mid_start != 0) && (c == 10);
      if (start_i) begin base_addr_i = 8'h40; word_cnt_i = 9'd5; end
      ram_gnt_i = (c > gnt_delay);
      tx_ready_i = (rdy_mode == 0) ? 1'b1 : (c % 2 == 1);
      if (c == 1) busy_c1 = busy_o;
      if (pv_hold && (!tx_valid_o || tx_data_o !== pv_data)) stab_err++;
      if (ram_req_o) begin
        req_cnt++;
        if (p_req && !p_gnt && ram_addr_o !== p_addr) req_moved++;
        if (!ram_gnt_i) req_stall++;
        else begin
          if (grant_c < 0) grant_c = c;
          addrs.push_back(ram_addr_o);
        end
      end
      if (tx_valid_o) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = c;
        if (tx_ready_i) begin got.push_back(tx_data_o); last_hs_c = c; end
      end
      pv_hold = tx_valid_o && !tx_ready_i; pv_data = tx_data_o;
      p_req = ram_req_o; p_gnt = ram_gnt_i; p_addr = ram_addr_o;
      if (done_o) begin done_cnt++; if (done_c < 0) done_c = c; end
      if (stop_bytes > 0 && got.size() == stop_bytes) begin timed_out = 0; break; end
      if (done_c >= 0 && c == done_c + 1) begin timed_out = 0; break; end
    end
    start_i = 1'b0;
    check("timeout", timed_out, 0);
  endtask

  initial begin
    for (int i = 0; i < NB; i++) begin
      mem[8'h10][DATA_W-1-8*i -: 8] = 8'(i + 1);
      mem[8'h11][DATA_W-1-8*i -: 8] = 8'(i) ^ 8'h55;
      mem[8'h12][DATA_W-1-8*i -: 8] = ~8'(i);
      mem[8'hFF][DATA_W-1-8*i -: 8] = 8'(i + 8'h80);
      mem[8'h00][DATA_W-1-8*i -: 8] = 8'(i * 7 + 3);
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;

    // single word, full-rate
    run_xfer(8'h10, 9'd1, 0, 0, 0, 0);
    build_exp(8'h10, 1);
    cmp_stream("single", exp_q.size());
    check("single_first_valid", first_valid, 3);
    check("single_busy_c1", busy_c1, 1);
    check("single_back_to_back", last_hs_c - first_valid, exp_q.size() - 1);
    check("single_done_cnt", done_cnt, 1);
    check("single_done_after_last", done_c, last_hs_c + 1);
    check("single_busy_after", busy_o, 0);
    check("single_nreads", addrs.size(), 1);
    check("single_addr", addrs.size() > 0 ? addrs[0] : 8'hxx, 8'h10);
    check("single_last_data", got.size() >= NB ? got[NB-1] : 8'hxx, 8'h60);
`ifdef CRG_READER_CKSUM_EN
    check("single_cksum", got.size() > NB ? got[NB] : 8'hxx, 8'h60);
`endif

    // zero count
    run_xfer(8'h20, 9'd0, 0, 0, 0, 0);
    check("zero_done_c", done_c, 1);
    check("zero_req", req_cnt, 0);
    check("zero_valid", valid_cnt, 0);
    check("zero_done_cnt", done_cnt, 1);
    check("zero_busy_after", busy_o, 0);

    // address wrap with back-pressure and an ignored mid-transfer start
    run_xfer(8'hFF, 9'd2, 1, 0, 0, 1);
    build_exp(8'hFF, 2);
    cmp_stream("wrap", exp_q.size());
    check("wrap_nreads", addrs.size(), 2);
    check("wrap_addr0", addrs.size() > 0 ? addrs[0] : 8'hxx, 8'hFF);
    check("wrap_addr1", addrs.size() > 1 ? addrs[1] : 8'hxx, 8'h00);
    check("wrap_stable", stab_err, 0);
    check("wrap_done_cnt", done_cnt, 1);

    // grant stall
    run_xfer(8'h10, 9'd1, 0, 5, 0, 0);
    build_exp(8'h10, 1);
    cmp_stream("stall", exp_q.size());
    check("stall_req_cycles", req_stall, 5);
    check("stall_addr_moved", req_moved, 0);
    check("stall_grant_c", grant_c, 6);
    check("stall_first_valid", first_valid, 8);

    // reset mid-stream after 40 bytes of a 3-word transfer
    run_xfer(8'h10, 9'd3, 0, 0, 40, 0);
    build_exp(8'h10, 3);
    cmp_stream("abort", 40);
    @(negedge clk);
    check("abort_no_done_pre", done_o, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("abort");
    @(negedge clk);
    rst_n = 1'b1;
    run_xfer(8'h10, 9'd1, 0, 0, 0, 0);
    build_exp(8'h10, 1);
    cmp_stream("rerun", exp_q.size());
    check("rerun_first_valid", first_valid, 3);
    check("rerun_done_cnt", done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/crg_result_reader.md
Name: crg_result_reader

Overview:
- Drains CRG result words from the 768-bit result RAM and serialises them into a byte stream for the UART transmit path.
- Sits between the result RAM read port and the UART TX byte interface; it is the reader for the RAM that the CRG core fills on dvld.
- The host programs a base address and word count, then pulses start; the block streams each word MSB byte first.

Parameters:
- DATA_W, 768, RAM word width; must be a multiple of 8.
- ADDR_W, 8, RAM address width; addresses wrap modulo 2^ADDR_W.
- CNT_W, 9, width of the word-count input; allows up to 256 words.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- start_i  input  1  one-cycle pulse to begin a transfer; sampled only in IDLE
- base_addr_i  input  ADDR_W  first RAM address; latched on an accepted start
- word_cnt_i  input  CNT_W  number of words to send; latched on an accepted start
- ram_req_o  output  1  read request to the RAM port
- ram_gnt_i  input  1  read granted this cycle; low while the CRG writer owns the port
- ram_addr_o  output  ADDR_W  read address
- ram_rdata_i  input  DATA_W  read data, valid exactly 1 cycle after a granted request
- tx_data_o  output  8  byte to the UART transmitter
- tx_valid_o  output  1  tx_data_o is valid
- tx_ready_i  input  1  UART transmitter accepts the byte
- busy_o  output  1  transfer in progress
- done_o  output  1  one-cycle pulse when a transfer completes

Behaviour:
- Reset values: ram_req_o=0, ram_addr_o=0, tx_valid_o=0, tx_data_o=0, busy_o=0, done_o=0; FSM in IDLE.
- Reset asserted mid-transfer aborts the transfer at the next clk edge. No done_o pulse is produced; the partial stream is simply truncated.
- FSM states:
  - IDLE → REQ on start_i with word_cnt_i != 0.
  - IDLE → DONE on start_i with word_cnt_i == 0; done_o pulses the next cycle, no bytes are sent.
  - REQ: ram_req_o=1, ram_addr_o=current address. Holds while ram_gnt_i=0. When ram_gnt_i=1 → WAIT.
  - WAIT: one cycle. Captures ram_rdata_i into a DATA_W shift register → SHIFT.
  - SHIFT: tx_valid_o=1, tx_data_o=shreg[DATA_W-1 -: 8]. On tx_valid_o && tx_ready_i, shift left by 8 and decrement the byte counter (DATA_W/8 bytes per word). After the last byte:
    - → CKSUM if the optional feature is enabled;
    - otherwise, → REQ if words remain, with address incremented and words-remaining decremented;
    - otherwise → DONE.
  - DONE: done_o=1 for one cycle, busy_o falls in the same cycle → IDLE.
- busy_o=1 in every state except IDLE.
- start_i outside IDLE is ignored; latched parameters do not change.
- Address increment wraps from 2^ADDR_W-1 to 0.
- Handshake rules:
  - tx_data_o is stable while tx_valid_o=1 and tx_ready_i=0.
  - tx_valid_o never depends combinationally on tx_ready_i.
  - Back-to-back bytes go out at one per cycle when tx_ready_i is held high.
- Latency from an accepted start to the first tx_valid_o: 3 cycles if ram_gnt_i is already high (REQ, WAIT, then first SHIFT cycle).
- All outputs are registered.

Optional Feature:
- Macro: CRG_READER_CKSUM_EN.
- Defined:
  - After the last data byte of each word, the block enters CKSUM and sends one extra byte: the XOR of all DATA_W/8 data bytes of that word, using the same handshake.
  - Next state is then REQ or DONE as above.
  - The XOR accumulator clears when WAIT captures a new word.
- Not defined: the CKSUM state and accumulator are absent; each word is exactly DATA_W/8 bytes.

Test Plan:
- Single word: RAM[0x10] = 768'h0102…5F60 (byte i = i+1), start with base=0x10, cnt=1, tx_ready_i=1, ram_gnt_i=1.
  → 96 bytes 0x01..0x60 in order on consecutive cycles; done_o pulses once; busy_o low afterwards.
- Zero count: start with cnt=0.
  → no ram_req_o, no tx_valid_o; done_o pulses 1 cycle after start.
- Wrap and back-pressure: base=0xFF, cnt=2, tx_ready_i toggling 1/0 every cycle.
  → reads address 0xFF then 0x00; 192 bytes sent; tx_data_o stable while tx_ready_i=0.
- Grant stall: hold ram_gnt_i=0 for 5 cycles after start.
  → ram_req_o held high with a stable address; first tx_valid_o appears 2 cycles after the grant.
- Reset mid-stream: rst_n=0 after 40 bytes of a 3-word transfer.
  → next cycle all outputs are at reset values; no done_o; a new start then runs normally.
- CRG_READER_CKSUM_EN defined, word with bytes 0x01..0x60:
  → 97th byte equals the XOR of 0x01..0x60, which is 0x60; then done_o pulses.
